pipe_stage_hs: RTL and testbench

PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 23 ++
 rtl/pipe_stage_hs.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_hs.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage.
// The skid slot is enabled with the PIPE_STAGE_SKID_EN macro (see pipe_stage_hs).
package pipe_pkg;

  // Stage occupancy states: nothing held, main slot held, main and skid held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  // Control word shown downstream when no valid entry is presented.
  localparam int                        DEFAULT_CTRL_W      = 16;
  localparam logic [DEFAULT_CTRL_W-1:0] BUBBLE_CTRL_DEFAULT = '0;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occupancy(input state_t s);
    logic [1:0] occ;
    case (s)
      FULL:    occ = 2'd1;
      SKID:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload+control register with load enable and synchronous clear.
// Reset and clear both return the slot to zero and win over load.
module pipe_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold, load or clear the stored word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register stage with optional skid slot.
// Define PIPE_STAGE_SKID_EN for a fully registered in_ready backed by a skid
// slot; without it in_ready is out_ready | ~out_valid and at most one entry
// is held.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high on that side. Once out_valid rises, out_data/out_ctrl stay
// put until the entry is released; out_valid never drops without a release
// except on flush or reset (reset > flush > handshake).
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 48,
  parameter int                 CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int SLOT_W = DATA_W + CTRL_W;

  // state is the FSM observation point for checkers.
  state_t            state;
  state_t            state_nxt;
  logic              valid_q;
  logic [1:0]        occ_q;
  logic              accept;
  logic              pop;
  logic              main_load;
  logic [SLOT_W-1:0] main_d;
  logic [SLOT_W-1:0] main_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              ready_q;
  logic              skid_load;
  logic              main_from_skid;
  logic [SLOT_W-1:0] skid_q;

  // Registered ready: only the SKID state refuses new entries.
  assign in_ready = ready_q;
  assign main_d   = main_from_skid ? skid_q : {in_data, in_ctrl};
`else
  // Without a skid slot the stage can take a new entry whenever the held one
  // leaves this cycle or nothing is held.
  assign in_ready = out_ready | ~valid_q;
  assign main_d   = {in_data, in_ctrl};
`endif

  assign accept    = in_valid & in_ready;
  assign pop       = valid_q & out_ready;
  assign out_valid = valid_q;
  assign occupancy = occ_q;
  assign out_data  = main_q[SLOT_W-1:CTRL_W];
  assign out_ctrl  = valid_q ? main_q[CTRL_W-1:0] : BUBBLE_CTRL;

  // Next state and slot load enables from the two handshakes.
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = FULL;
          main_load = 1'b1;
        end
      end
      FULL: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
        end else if (accept) begin
          state_nxt = SKID;
          skid_load = 1'b1;
`endif
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      SKID: begin
        if (pop) begin
          state_nxt      = FULL;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
`endif
      default: state_nxt = EMPTY;
    endcase
  end

  // FSM state with registered valid/ready/occupancy decoded from next state.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      occ_q   <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt != EMPTY);
      occ_q   <= state_occupancy(state_nxt);
`ifdef PIPE_STAGE_SKID_EN
      ready_q <= (state_nxt != SKID);
`endif
    end
  end

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(.W(SLOT_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (skid_load),
    .d     ({in_data, in_ctrl}),
    .q     (skid_q)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and random bench for pipe_stage_hs (DATA_W=48, CTRL_W=16,
// BUBBLE_CTRL=0). Expectations follow PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_hs;

  localparam int DATA_W = 48;
  localparam int CTRL_W = 16;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit HAS_SKID = 1'b1;
`else
  localparam bit HAS_SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  int checks = 0;
  int failures = 0;
  logic [DATA_W+CTRL_W-1:0] exp_q[$];

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pipe_stage_hs #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  // Advance one clock, landing 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
    checks++; if (out_data !== 48'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_ctrl !== 16'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 48'(k);
      in_ctrl  = 16'h1100 + 16'(k);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 48'(k) || out_ctrl !== 16'h1100 + 16'(k) || occupancy !== 2'd1) begin
        failures++;
        $display("FAIL stream_%0d got v=%0b d=%h c=%h o=%0d exp v=1 d=%h c=%h o=1",
                 k, out_valid, out_data, out_ctrl, occupancy, 48'(k), 16'h1100 + 16'(k));
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 48'h8) begin
      failures++;
      $display("FAIL stream_bubble got v=%0b d=%h c=%h exp v=0 d=8 c=0", out_valid, out_data, out_ctrl);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'hA;
    in_ctrl   = 16'h00AA;
    step();
    checks++; if (in_ready !== HAS_SKID) begin failures++; $display("FAIL stall_ready_full got=%0b exp=%0b", in_ready, HAS_SKID); end
    in_data = 48'hB;
    in_ctrl = 16'h00BB;
    step();
    checks++; if (occupancy !== (HAS_SKID ? 2'd2 : 2'd1)) begin failures++; $display("FAIL stall_occ got=%0d exp=%0d", occupancy, HAS_SKID ? 2 : 1); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0b exp=0", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 48'hA || out_ctrl !== 16'h00AA) begin
      failures++;
      $display("FAIL stall_hold got v=%0b d=%h c=%h exp v=1 d=a c=aa", out_valid, out_data, out_ctrl);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== !HAS_SKID) begin failures++; $display("FAIL stall_ready_comb got=%0b exp=%0b", in_ready, !HAS_SKID); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 48'hB || out_ctrl !== 16'h00BB || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL stall_second got v=%0b d=%h c=%h o=%0d exp v=1 d=b c=bb o=1", out_valid, out_data, out_ctrl, occupancy);
    end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 48'hB) begin failures++; $display("FAIL stall_drain got v=%0b d=%h exp v=0 d=b", out_valid, out_data); end
  endtask

  task automatic test_flush();
    bit leaked;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'hD;
    in_ctrl   = 16'h00DD;
    step();
    in_data = 48'hE;
    in_ctrl = 16'h00EE;
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 48'hC;
    in_ctrl   = 16'h00CC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (out_ctrl !== 16'h0) begin failures++; $display("FAIL flush_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (out_data !== 48'h0) begin failures++; $display("FAIL flush_data got=%h exp=0", out_data); end
    leaked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b0) leaked = 1'b1;
    end
    checks++; if (leaked !== 1'b0) begin failures++; $display("FAIL flush_leak got=%0b exp=0", leaked); end
    // Flush while empty must also drop the entry offered that cycle.
    in_valid = 1'b1;
    in_data  = 48'hF;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush_empty got v=%0b o=%0d exp v=0 o=0", out_valid, occupancy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'h5;
    in_ctrl   = 16'h0055;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 48'h5) begin failures++; $display("FAIL rstmid_load got v=%0b d=%h exp v=1 d=5", out_valid, out_data); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 16'h0 || out_data !== 48'h0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL rstmid got v=%0b r=%0b c=%h d=%h o=%0d exp v=0 r=1 c=0 d=0 o=0",
               out_valid, in_ready, out_ctrl, out_data, occupancy);
    end
  endtask

  task automatic test_random();
    bit acc;
    bit rel;
    logic [DATA_W+CTRL_W-1:0] exp_w;
    exp_q.delete();
    for (int cyc = 0; cyc < 10000 + 6; cyc++) begin
      if (cyc < 10000) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 3) != 0);
        in_data   = {16'($urandom()), $urandom()};
        in_ctrl   = 16'($urandom());
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      checks++;
      if (occupancy !== 2'(exp_q.size())) begin
        failures++;
        $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, exp_q.size());
      end
      if (!out_valid) begin
        checks++;
        if (out_ctrl !== 16'h0) begin failures++; $display("FAIL rand_bubble cyc=%0d got=%h exp=0", cyc, out_ctrl); end
      end
      acc = in_valid && in_ready;
      rel = out_valid && out_ready;
      if (rel) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_dup cyc=%0d got=%h exp=<none>", cyc, {out_data, out_ctrl});
        end else begin
          exp_w = exp_q.pop_front();
          if ({out_data, out_ctrl} !== exp_w) begin
            failures++;
            $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, {out_data, out_ctrl}, exp_w);
          end
        end
      end
      if (acc) exp_q.push_back({in_data, in_ctrl});
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_loss got=%0d exp=0", exp_q.size()); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
